// File: rtl/smart_led_pkg.sv
// Shared frame geometry and FSM encoding for the smart-LED serial frame receiver.
package smart_led_pkg;

  localparam int FRAME_W = 32;
  localparam int DATA_W  = 30;
  localparam int USE_BIT = 30;
  localparam int PAR_BIT = 31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_e;

endpackage

// File: rtl/smart_led_sync_edge.sv
// Two-flop synchroniser for the incoming serial clock/data pair plus rising-edge detect.
module smart_led_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_async_i,
  input  logic data_async_i,
  output logic d2_o,
  output logic c3_o,
  output logic rise_o
);

  logic c1_q, c2_q, c3_q;
  logic d1_q, d2_q;

  // Synchroniser chain; c3 is one stage behind c2 for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c1_q <= 1'b0;
      c2_q <= 1'b0;
      c3_q <= 1'b0;
      d1_q <= 1'b0;
      d2_q <= 1'b0;
    end else begin
      c1_q <= clk_async_i;
      c2_q <= c1_q;
      c3_q <= c2_q;
      d1_q <= data_async_i;
      d2_q <= d1_q;
    end
  end

  assign d2_o   = d2_q;
  assign c3_o   = c3_q;
  assign rise_o = c2_q & ~c3_q;

endmodule

// File: rtl/smart_led_frame_receiver.sv
// Smart-LED daisy-chain stage: assembles 32-bit frames, claims the first unused one after an
// idle gap, and re-serialises every frame downstream with the claimed frame marked as used.
module smart_led_frame_receiver
  import smart_led_pkg::*;
#(
  parameter int DATA_W      = smart_led_pkg::DATA_W,
  parameter int TIMEOUT_CYC = 255,
  parameter int TO_W        = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_data_i,
  input  logic              in_clock_i,
  output logic [DATA_W-1:0] led_data_o,
  output logic              led_valid_o,
  output logic              parity_err_o,
  output logic              claimed_o,
  output logic              fwd_data_o,
  output logic              fwd_clock_o
);

  localparam int FRM_W = DATA_W + 2;
  localparam int BC_W  = $clog2(FRM_W);
  localparam logic [BC_W-1:0] FIRST_IDX = BC_W'(0);
  localparam logic [BC_W-1:0] USE_IDX   = BC_W'(DATA_W);
  localparam logic [BC_W-1:0] PAR_IDX   = BC_W'(DATA_W + 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0] TO_MAX    = TO_W'(TIMEOUT_CYC);

  logic d2_s, c3_s, rise_s;

  smart_led_sync_edge u_sync (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk_async_i  (in_clock_i),
    .data_async_i (in_data_i),
    .d2_o         (d2_s),
    .c3_o         (c3_s),
    .rise_o       (rise_s)
  );

  state_e            state_q, state_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [FRM_W-1:0]  sr_q, sr_d;
  logic              par_q, par_d;
  logic              flip_q, flip_d;
  logic [TO_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic              claimed_q, claimed_d;
  logic [DATA_W-1:0] led_data_q, led_data_d;
  logic              led_valid_q, led_valid_d;
  logic              parity_err_q, parity_err_d;
  logic              fwd_data_q, fwd_data_d;
  logic              fwd_clock_q, fwd_clock_d;

  // Effective pre-rise view: a timeout in the same cycle as a rise is applied first.
  logic              to_s;
  state_e            state_eff_s;
  logic              claimed_eff_s;
  logic              flip_eff_s;
  logic [BC_W-1:0]   bidx_s;
  logic              fwd_bit_s;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      sr_q         <= '0;
      par_q        <= 1'b0;
      flip_q       <= 1'b0;
      idle_cnt_q   <= '0;
      claimed_q    <= 1'b0;
      led_data_q   <= '0;
      led_valid_q  <= 1'b0;
      parity_err_q <= 1'b0;
      fwd_data_q   <= 1'b0;
      fwd_clock_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      sr_q         <= sr_d;
      par_q        <= par_d;
      flip_q       <= flip_d;
      idle_cnt_q   <= idle_cnt_d;
      claimed_q    <= claimed_d;
      led_data_q   <= led_data_d;
      led_valid_q  <= led_valid_d;
      parity_err_q <= parity_err_d;
      fwd_data_q   <= fwd_data_d;
      fwd_clock_q  <= fwd_clock_d;
    end
  end

  // Next-state: idle timeout, frame check, then shift/forward on a serial clock rise.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    sr_d         = sr_q;
    par_d        = par_q;
    flip_d       = flip_q;
    idle_cnt_d   = idle_cnt_q;
    claimed_d    = claimed_q;
    led_data_d   = led_data_q;
    led_valid_d  = 1'b0;
    parity_err_d = 1'b0;
    fwd_data_d   = fwd_data_q;
    fwd_clock_d  = c3_s;
    fwd_bit_s    = d2_s;
    bidx_s       = FIRST_IDX;

    to_s          = (idle_cnt_q >= TO_LAST);
    state_eff_s   = to_s ? IDLE : state_q;
    claimed_eff_s = to_s ? 1'b0 : claimed_q;
    flip_eff_s    = to_s ? 1'b0 : flip_q;

    if (rise_s) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != TO_MAX) begin
      idle_cnt_d = idle_cnt_q + TO_W'(1);
    end else begin
      idle_cnt_d = idle_cnt_q;
    end

    if (state_q == CHECK) begin
      state_d = IDLE;
      if (par_q) begin
        parity_err_d = 1'b1;
      end else if (!sr_q[DATA_W] && !claimed_q) begin
        led_data_d  = sr_q[DATA_W-1:0];
        led_valid_d = 1'b1;
        claimed_d   = 1'b1;
      end else begin
        led_valid_d = 1'b0;
      end
    end else begin
      led_valid_d = 1'b0;
    end

    if (to_s) begin
      bit_cnt_d = '0;
      par_d     = 1'b0;
      flip_d    = 1'b0;
      claimed_d = 1'b0;
      state_d   = IDLE;
    end else begin
      flip_d = flip_q;
    end

    if (rise_s) begin
      bidx_s    = (state_eff_s == SHIFT) ? bit_cnt_q : FIRST_IDX;
      sr_d      = {d2_s, sr_q[FRM_W-1:1]};
      par_d     = (bidx_s == FIRST_IDX) ? d2_s : (par_q ^ d2_s);
      bit_cnt_d = (bidx_s == PAR_IDX) ? FIRST_IDX : (bidx_s + BC_W'(1));
      state_d   = (bidx_s == PAR_IDX) ? CHECK : SHIFT;
      case (bidx_s)
        FIRST_IDX: begin
          flip_d = 1'b0;
        end
        USE_IDX: begin
          if (!claimed_eff_s && !d2_s) begin
            fwd_bit_s = 1'b1;
            flip_d    = 1'b1;
          end else begin
            fwd_bit_s = d2_s;
          end
        end
        PAR_IDX: begin
          fwd_bit_s = d2_s ^ flip_eff_s;
          flip_d    = 1'b0;
        end
        default: begin
          fwd_bit_s = d2_s;
        end
      endcase
      fwd_data_d = fwd_bit_s;
    end else begin
      fwd_data_d = fwd_data_q;
    end
  end

  assign led_data_o   = led_data_q;
  assign led_valid_o  = led_valid_q;
  assign parity_err_o = parity_err_q;
  assign claimed_o    = claimed_q;
  assign fwd_data_o   = fwd_data_q;
  assign fwd_clock_o  = fwd_clock_q;

endmodule

// File: tb/tb_smart_led_frame_receiver.sv
// Directed bench for smart_led_frame_receiver: drives serial frames and collects the forwarded stream.
module tb_smart_led_frame_receiver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_data = 1'b0;
  logic        in_clock = 1'b0;
  logic [29:0] led_data;
  logic        led_valid, parity_err, claimed, fwd_data, fwd_clock;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [31:0] fw_sr = 32'h0;
  int          fw_cnt = 0;
  logic        prev_fc = 1'b0;
  int          valid_cnt = 0;
  int          perr_cnt = 0;
  int          bad_pulse_cnt = 0;
  logic        prev_v = 1'b0;
  logic        prev_p = 1'b0;

  smart_led_frame_receiver dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data_i    (in_data),
    .in_clock_i   (in_clock),
    .led_data_o   (led_data),
    .led_valid_o  (led_valid),
    .parity_err_o (parity_err),
    .claimed_o    (claimed),
    .fwd_data_o   (fwd_data),
    .fwd_clock_o  (fwd_clock)
  );

  always #5 clk = ~clk;

  // Downstream LED model plus pulse counters.
  always @(negedge clk) begin
    prev_fc <= fwd_clock;
    if (fwd_clock && !prev_fc) begin
      fw_sr  <= {fwd_data, fw_sr[31:1]};
      fw_cnt <= fw_cnt + 1;
    end
    if (led_valid) valid_cnt <= valid_cnt + 1;
    if (parity_err) perr_cnt <= perr_cnt + 1;
    if ((led_valid && parity_err) || (led_valid && prev_v) || (parity_err && prev_p))
      bad_pulse_cnt <= bad_pulse_cnt + 1;
    prev_v <= led_valid;
    prev_p <= parity_err;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      in_data = w[i];
      tick(4);
      in_clock = 1'b1;
      tick(4);
      in_clock = 1'b0;
    end
  endtask

  task automatic do_frame(input logic [31:0] w, output logic [31:0] fwd, output logic ok);
    int start;
    int n;
    start = fw_cnt;
    send_bits(w, 32);
    n = 0;
    while ((fw_cnt - start) < 32 && n < 100) begin
      tick(1);
      n++;
    end
    ok = ((fw_cnt - start) >= 32);
    tick(6);
    fwd = fw_sr;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_clock = 1'b0;
    in_data = 1'b0;
    tick(4);
    chk_cnt++;
    if ({led_valid, parity_err, claimed, fwd_data, fwd_clock} !== 5'b0)
      $display("FAIL reset_flags: got %b want 00000", {led_valid, parity_err, claimed, fwd_data, fwd_clock});
    else pass_cnt++;
    chk_cnt++;
    if (led_data !== 30'h0) $display("FAIL reset_led_data: got %h want 0", led_data);
    else pass_cnt++;
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_claim;
    logic [31:0] fwd;
    logic ok;
    int v0, p0;
    v0 = valid_cnt;
    p0 = perr_cnt;
    do_frame(32'h8000_0001, fwd, ok);
    chk_cnt++;
    if (ok !== 1'b1) $display("FAIL t1_fwd_timeout: got %0d bits want 32", fw_cnt);
    else pass_cnt++;
    chk_cnt++;
    if (fwd !== 32'h4000_0001) $display("FAIL t1_fwd_word: got %h want 40000001", fwd);
    else pass_cnt++;
    chk_cnt++;
    if (led_data !== 30'h1) $display("FAIL t1_led_data: got %h want 1", led_data);
    else pass_cnt++;
    chk_cnt++;
    if (claimed !== 1'b1) $display("FAIL t1_claimed: got %b want 1", claimed);
    else pass_cnt++;
    chk_cnt++;
    if ((valid_cnt - v0) != 1 || (perr_cnt - p0) != 0)
      $display("FAIL t1_pulses: got valid %0d perr %0d want 1 0", valid_cnt - v0, perr_cnt - p0);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] fwd;
    logic ok;
    int v0;
    v0 = valid_cnt;
    do_frame(32'h8000_0002, fwd, ok);
    chk_cnt++;
    if (ok !== 1'b1 || fwd !== 32'h8000_0002) $display("FAIL t2_fwd_word: got %h ok %b want 80000002", fwd, ok);
    else pass_cnt++;
    chk_cnt++;
    if ((valid_cnt - v0) != 0) $display("FAIL t2_no_valid: got %0d pulses want 0", valid_cnt - v0);
    else pass_cnt++;
    chk_cnt++;
    if (led_data !== 30'h1 || claimed !== 1'b1)
      $display("FAIL t2_hold: got led_data %h claimed %b want 1 1", led_data, claimed);
    else pass_cnt++;
  endtask

  task automatic test_idle_reclaim;
    logic [31:0] fwd;
    logic ok;
    int v0;
    tick(200);
    chk_cnt++;
    if (claimed !== 1'b1) $display("FAIL t3_claimed_before_timeout: got %b want 1", claimed);
    else pass_cnt++;
    tick(100);
    chk_cnt++;
    if (claimed !== 1'b0) $display("FAIL t3_claimed_after_timeout: got %b want 0", claimed);
    else pass_cnt++;
    v0 = valid_cnt;
    do_frame(32'h0000_0003, fwd, ok);
    chk_cnt++;
    if (ok !== 1'b1 || fwd !== 32'hC000_0003) $display("FAIL t3_fwd_word: got %h ok %b want c0000003", fwd, ok);
    else pass_cnt++;
    chk_cnt++;
    if (led_data !== 30'h3 || claimed !== 1'b1 || (valid_cnt - v0) != 1)
      $display("FAIL t3_claim: got led_data %h claimed %b valid %0d want 3 1 1", led_data, claimed, valid_cnt - v0);
    else pass_cnt++;
  endtask

  task automatic test_parity_error;
    logic [31:0] fwd;
    logic ok;
    int v0, p0;
    tick(300);
    v0 = valid_cnt;
    p0 = perr_cnt;
    do_frame(32'h0000_0001, fwd, ok);
    chk_cnt++;
    if ((perr_cnt - p0) != 1 || (valid_cnt - v0) != 0)
      $display("FAIL t4_pulses: got perr %0d valid %0d want 1 0", perr_cnt - p0, valid_cnt - v0);
    else pass_cnt++;
    chk_cnt++;
    if (claimed !== 1'b0 || led_data !== 30'h3)
      $display("FAIL t4_hold: got claimed %b led_data %h want 0 3", claimed, led_data);
    else pass_cnt++;
    chk_cnt++;
    if (ok !== 1'b1 || fwd !== 32'hC000_0001) $display("FAIL t4_fwd_word: got %h ok %b want c0000001", fwd, ok);
    else pass_cnt++;
  endtask

  task automatic test_partial_frame;
    logic [31:0] fwd;
    logic ok;
    int v0, p0;
    v0 = valid_cnt;
    p0 = perr_cnt;
    send_bits(32'h000A_5555, 20);
    tick(300);
    chk_cnt++;
    if ((perr_cnt - p0) != 0 || (valid_cnt - v0) != 0)
      $display("FAIL t5_partial_pulses: got perr %0d valid %0d want 0 0", perr_cnt - p0, valid_cnt - v0);
    else pass_cnt++;
    do_frame(32'h8000_0007, fwd, ok);
    chk_cnt++;
    if (led_data !== 30'h7 || claimed !== 1'b1 || (valid_cnt - v0) != 1)
      $display("FAIL t5_claim: got led_data %h claimed %b valid %0d want 7 1 1", led_data, claimed, valid_cnt - v0);
    else pass_cnt++;
    chk_cnt++;
    if (ok !== 1'b1 || fwd !== 32'h4000_0007) $display("FAIL t5_fwd_word: got %h ok %b want 40000007", fwd, ok);
    else pass_cnt++;
  endtask

  task automatic test_reset_midframe;
    logic [31:0] fwd;
    logic ok;
    int v0;
    send_bits(32'h0000_7FFF, 15);
    rst_n = 1'b0;
    tick(3);
    chk_cnt++;
    if ({led_valid, parity_err, claimed, fwd_data, fwd_clock} !== 5'b0)
      $display("FAIL t6_reset_flags: got %b want 00000", {led_valid, parity_err, claimed, fwd_data, fwd_clock});
    else pass_cnt++;
    chk_cnt++;
    if (led_data !== 30'h0) $display("FAIL t6_reset_led_data: got %h want 0", led_data);
    else pass_cnt++;
    rst_n = 1'b1;
    tick(2);
    v0 = valid_cnt;
    do_frame(32'h0000_0005, fwd, ok);
    chk_cnt++;
    if (led_data !== 30'h5 || claimed !== 1'b1 || (valid_cnt - v0) != 1)
      $display("FAIL t6_claim: got led_data %h claimed %b valid %0d want 5 1 1", led_data, claimed, valid_cnt - v0);
    else pass_cnt++;
    chk_cnt++;
    if (ok !== 1'b1 || fwd !== 32'hC000_0005) $display("FAIL t6_fwd_word: got %h ok %b want c0000005", fwd, ok);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_claim();
    test_back_to_back();
    test_idle_reclaim();
    test_parity_error();
    test_partial_frame();
    test_reset_midframe();
    tick(2);
    chk_cnt++;
    if (bad_pulse_cnt != 0) $display("FAIL pulse_shape: got %0d bad pulses want 0", bad_pulse_cnt);
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
